// File: rtl/uart_frame_sender.sv
// Byte serialiser: latches one frame of NUM_CH x WORD_BYTES bytes (plus an optional sync byte)
// and hands it to a UART transmitter one byte at a time over the Tx_en / Tx_Ready_To_Send handshake.
module uart_frame_sender #(
    parameter int          NUM_CH     = 2,
    parameter int          WORD_BYTES = 2,
    parameter int          MSB_FIRST  = 0,
    parameter int          SYNC_EN    = 1,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int          TIMEOUT    = 1023
) (
    input  logic                             clk,
    input  logic                             reset_b,
    input  logic                             frame_valid,
    input  logic [NUM_CH*WORD_BYTES*8-1:0]   frame_data,
    output logic                             frame_ready,
    output logic                             frame_ack,
    input  logic                             Tx_Ready_To_Send,
    output logic                             Tx_en,
    output logic [7:0]                       tx_byte,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             timeout_err
);

    localparam int TOTAL   = SYNC_EN + NUM_CH * WORD_BYTES;
    localparam int DATA_W  = NUM_CH * WORD_BYTES * 8;
    localparam int IDX_W   = $clog2(TOTAL + 1);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENABLE = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [IDX_W-1:0]     index_r;
    logic [DATA_W-1:0]    hold_r;
    logic [STALL_W-1:0]   stall_r;
    logic [7:0]           tx_byte_r;
    logic                 frame_ack_r, frame_done_r, timeout_err_r;
    logic                 transfer_s, advance_s, done_evt_s, timeout_evt_s;
    logic                 frame_ready_s, tx_en_s, busy_s;

    // Maps a frame position to its byte: sync byte first, then channel words in the chosen byte order.
    function automatic logic [7:0] select_byte(input logic [DATA_W-1:0] data,
                                               input logic [IDX_W-1:0]  idx);
        int k, c, p, pos;
        logic [7:0] b;
        b = 8'h00;
        if ((SYNC_EN != 0) && (idx == {IDX_W{1'b0}})) begin
            b = SYNC_BYTE;
        end else begin
            k   = int'(idx) - SYNC_EN;
            c   = k / WORD_BYTES;
            p   = k % WORD_BYTES;
            pos = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - p) : p;
            b   = data[(c * WORD_BYTES + pos) * 8 +: 8];
        end
        return b;
    endfunction

    assign frame_ready_s = (state_r == IDLE) && Tx_Ready_To_Send;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and the single-cycle events that steer the datapath.
    always_comb begin
        state_nxt_s   = state_r;
        transfer_s    = 1'b0;
        advance_s     = 1'b0;
        done_evt_s    = 1'b0;
        timeout_evt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (frame_valid && frame_ready_s) begin
                    state_nxt_s = ENABLE;
                    transfer_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ENABLE: begin
                if (!Tx_Ready_To_Send) begin
                    state_nxt_s = SEND;
                end else if (stall_r == STALL_W'(TIMEOUT - 1)) begin
                    state_nxt_s   = IDLE;
                    timeout_evt_s = 1'b1;
                end else begin
                    state_nxt_s = ENABLE;
                end
            end
            SEND: begin
                if (!Tx_Ready_To_Send) begin
                    state_nxt_s = SEND;
                end else if (index_r == IDX_W'(TOTAL - 1)) begin
                    state_nxt_s = IDLE;
                    done_evt_s  = 1'b1;
                end else begin
                    state_nxt_s = ENABLE;
                    advance_s   = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        tx_en_s = 1'b0;
        busy_s  = 1'b0;
        case (state_r)
            IDLE:    begin tx_en_s = 1'b0; busy_s = 1'b0; end
            ENABLE:  begin tx_en_s = 1'b1; busy_s = 1'b1; end
            SEND:    begin tx_en_s = 1'b0; busy_s = 1'b1; end
            default: begin tx_en_s = 1'b0; busy_s = 1'b0; end
        endcase
    end

    // Hold register, byte index, presented byte and status pulses.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            hold_r        <= {DATA_W{1'b0}};
            index_r       <= {IDX_W{1'b0}};
            tx_byte_r     <= 8'h00;
            stall_r       <= {STALL_W{1'b0}};
            frame_ack_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            frame_ack_r   <= transfer_s;
            frame_done_r  <= done_evt_s;
            timeout_err_r <= timeout_evt_s;
            // The stall counter only runs while ENABLE waits for the TX to go busy.
            if ((state_r == ENABLE) && Tx_Ready_To_Send) begin
                stall_r <= stall_r + STALL_W'(1);
            end else begin
                stall_r <= {STALL_W{1'b0}};
            end
            if (transfer_s) begin
                hold_r    <= frame_data;
                index_r   <= {IDX_W{1'b0}};
                tx_byte_r <= select_byte(frame_data, {IDX_W{1'b0}});
            end else if (advance_s) begin
                index_r   <= index_r + IDX_W'(1);
                tx_byte_r <= select_byte(hold_r, index_r + IDX_W'(1));
            end else begin
                hold_r    <= hold_r;
                index_r   <= index_r;
                tx_byte_r <= tx_byte_r;
            end
        end
    end

    assign frame_ready = frame_ready_s;
    assign frame_ack   = frame_ack_r;
    assign Tx_en       = tx_en_s;
    assign busy        = busy_s;
    assign tx_byte     = tx_byte_r;
    assign frame_done  = frame_done_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Bench for uart_frame_sender: three parameterisations driven by a TX model, bytes compared
// against an expected stream built from the frame layout rules.
module tb_uart_frame_sender;

    localparam int NC_P  [3] = '{2, 2, 3};
    localparam int WB_P  [3] = '{2, 2, 3};
    localparam int MSB_P [3] = '{0, 1, 1};
    localparam int SYN_P [3] = '{1, 0, 1};

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [71:0] fd = 72'h0;
    logic        fv      [3] = '{1'b0, 1'b0, 1'b0};
    logic        frdy    [3];
    logic        ack     [3];
    logic        en      [3];
    logic        bsy     [3];
    logic        done    [3];
    logic        terr    [3];
    logic        rdy     [3];
    logic [7:0]  tb_byte [3];

    int   cnt      [3] = '{0, 0, 0};
    int   busy_len [3] = '{4, 4, 4};
    bit   stuck    [3] = '{1'b0, 1'b0, 1'b0};
    int   ack_cnt  [3] = '{0, 0, 0};
    int   done_cnt [3] = '{0, 0, 0};
    int   to_cnt   [3] = '{0, 0, 0};
    int   en_cyc   [3] = '{0, 0, 0};
    int   en_rise  [3] = '{0, 0, 0};
    logic       prev_en   [3] = '{1'b0, 1'b0, 1'b0};
    logic       prev_bsy  [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] prev_byte [3] = '{8'h0, 8'h0, 8'h0};

    logic [7:0] mon_q[$];
    logic [7:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_frame_sender #(.NUM_CH(2), .WORD_BYTES(2), .MSB_FIRST(0), .SYNC_EN(1),
                        .SYNC_BYTE(8'hA5), .TIMEOUT(8)) u_a (
        .clk(clk), .reset_b(reset_b), .frame_valid(fv[0]), .frame_data(fd[31:0]),
        .frame_ready(frdy[0]), .frame_ack(ack[0]), .Tx_Ready_To_Send(rdy[0]),
        .Tx_en(en[0]), .tx_byte(tb_byte[0]), .busy(bsy[0]),
        .frame_done(done[0]), .timeout_err(terr[0]));

    uart_frame_sender #(.NUM_CH(2), .WORD_BYTES(2), .MSB_FIRST(1), .SYNC_EN(0),
                        .SYNC_BYTE(8'hA5), .TIMEOUT(1023)) u_b (
        .clk(clk), .reset_b(reset_b), .frame_valid(fv[1]), .frame_data(fd[31:0]),
        .frame_ready(frdy[1]), .frame_ack(ack[1]), .Tx_Ready_To_Send(rdy[1]),
        .Tx_en(en[1]), .tx_byte(tb_byte[1]), .busy(bsy[1]),
        .frame_done(done[1]), .timeout_err(terr[1]));

    uart_frame_sender #(.NUM_CH(3), .WORD_BYTES(3), .MSB_FIRST(1), .SYNC_EN(1),
                        .SYNC_BYTE(8'hA5), .TIMEOUT(1023)) u_c (
        .clk(clk), .reset_b(reset_b), .frame_valid(fv[2]), .frame_data(fd),
        .frame_ready(frdy[2]), .frame_ack(ack[2]), .Tx_Ready_To_Send(rdy[2]),
        .Tx_en(en[2]), .tx_byte(tb_byte[2]), .busy(bsy[2]),
        .frame_done(done[2]), .timeout_err(terr[2]));

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // TX model: goes busy the cycle after it sees Tx_en, stays busy busy_len cycles (0 = random).
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cnt[i] != 0) cnt[i] <= cnt[i] - 1;
            else if (en[i] === 1'b1 && !stuck[i])
                cnt[i] <= (busy_len[i] == 0) ? int'($urandom_range(1, 6)) : busy_len[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) rdy[i] = (cnt[i] == 0);
    end

    // Monitor: captures bytes on Tx_en rising edges, counts pulses, checks in-frame invariants.
    always @(negedge clk) begin
        if (reset_b) begin
            for (int i = 0; i < 3; i++) begin
                if (en[i] === 1'b1 && prev_en[i] !== 1'b1) begin
                    mon_q.push_back(tb_byte[i]);
                    en_rise[i]++;
                end else if (bsy[i] === 1'b1 && prev_bsy[i] === 1'b1) begin
                    check("byte_stable", {64'h0, tb_byte[i]}, {64'h0, prev_byte[i]});
                end
                if (bsy[i] === 1'b1) check("ready_while_busy", {71'h0, frdy[i]}, 72'h0);
                if (done[i] === 1'b1 || terr[i] === 1'b1)
                    check("done_xor_timeout", {71'h0, done[i] & terr[i]}, 72'h0);
                if (en[i] === 1'b1) en_cyc[i]++;
                if (ack[i] === 1'b1) ack_cnt[i]++;
                if (done[i] === 1'b1) done_cnt[i]++;
                if (terr[i] === 1'b1) to_cnt[i]++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            prev_en[i] = en[i];
            prev_bsy[i] = bsy[i];
            prev_byte[i] = tb_byte[i];
        end
    end

    // Expected byte stream: optional sync, then channels in order, each word in its byte order.
    task automatic build_exp(input int i, input logic [71:0] d);
        logic [71:0] dv;
        dv = d;
        if (SYN_P[i] != 0) exp_q.push_back(8'hA5);
        for (int c = 0; c < NC_P[i]; c++)
            for (int p = 0; p < WB_P[i]; p++) begin
                int b;
                b = c * WB_P[i] + ((MSB_P[i] != 0) ? (WB_P[i] - 1 - p) : p);
                exp_q.push_back(dv[b*8 +: 8]);
            end
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_count"}, 72'(mon_q.size()), 72'(exp_q.size()));
        for (int k = 0; k < mon_q.size() && k < exp_q.size(); k++)
            check($sformatf("%s_b%0d", tag, k), {64'h0, mon_q[k]}, {64'h0, exp_q[k]});
        mon_q.delete();
        exp_q.delete();
    endtask

    task automatic start_frame(input int i, input logic [71:0] d);
        int c;
        c = 0;
        while (frdy[i] !== 1'b1 && c < 200) begin @(posedge clk); #1; c++; end
        check("ready_wait", {71'h0, frdy[i]}, 72'h1);
        mon_q.delete();
        exp_q.delete();
        build_exp(i, d);
        fd = d;
        fv[i] = 1'b1;
        @(posedge clk); #1;
        fv[i] = 1'b0;
        check("frame_ack", {71'h0, ack[i]}, 72'h1);
        check("tx_en_latency", {71'h0, en[i]}, 72'h1);
    endtask

    task automatic wait_end(input int i, input int target);
        for (int c = 0; c < 3000 && (done_cnt[i] + to_cnt[i]) < target; c++) @(negedge clk);
        check("wait_end", 72'((done_cnt[i] + to_cnt[i]) >= target), 72'h1);
    endtask

    task automatic run_frame(input int i, input logic [71:0] d, input string tag);
        int tgt;
        tgt = done_cnt[i] + to_cnt[i] + 1;
        start_frame(i, d);
        wait_end(i, tgt);
        #1;
        check({tag, "_busy_low"}, {71'h0, bsy[i]}, 72'h0);
        compare_q(tag);
    endtask

    initial begin
        int d0, t0, e0, a0, r0, nxf, tgt;
        logic take;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_tx_en", {71'h0, en[i]}, 72'h0);
            check("rst_busy", {71'h0, bsy[i]}, 72'h0);
            check("rst_ack", {71'h0, ack[i]}, 72'h0);
            check("rst_done", {71'h0, done[i]}, 72'h0);
            check("rst_terr", {71'h0, terr[i]}, 72'h0);
            check("rst_byte", {64'h0, tb_byte[i]}, 72'h0);
        end
        reset_b = 1'b1;
        @(posedge clk); #1;

        // Defaults, LSB first with sync.
        d0 = done_cnt[0];
        run_frame(0, 72'h44332211, "t1");
        check("t1_done_pulses", 72'(done_cnt[0] - d0), 72'h1);

        // MSB first, no sync: 22,11,44,33 with four Tx_en rising edges.
        r0 = en_rise[1];
        run_frame(1, 72'h44332211, "t2");
        check("t2_tx_en_rises", 72'(en_rise[1] - r0), 72'h4);

        // frame_valid held high with data churning: exactly two frames, each the value at its ack edge.
        mon_q.delete(); exp_q.delete();
        a0 = ack_cnt[0]; tgt = done_cnt[0] + to_cnt[0] + 2; nxf = 0;
        fv[0] = 1'b1;
        for (int c = 0; c < 400 && nxf < 2; c++) begin
            fd = {8'($urandom), $urandom, $urandom};
            take = frdy[0];
            @(posedge clk);
            if (take === 1'b1) begin build_exp(0, fd); nxf++; end
            #1;
        end
        fv[0] = 1'b0;
        wait_end(0, tgt);
        repeat (2) @(posedge clk); #1;
        check("t3_frames", 72'(nxf), 72'h2);
        check("t3_acks", 72'(ack_cnt[0] - a0), 72'h2);
        compare_q("t3");

        // TX never goes busy: eight Tx_en cycles then a single timeout pulse.
        stuck[0] = 1'b1;
        d0 = done_cnt[0]; t0 = to_cnt[0]; e0 = en_cyc[0];
        start_frame(0, 72'h0BADF00D);
        wait_end(0, d0 + t0 + 1);
        #1;
        check("t4_busy_low", {71'h0, bsy[0]}, 72'h0);
        repeat (4) @(posedge clk); #1;
        check("t4_tx_en_cycles", 72'(en_cyc[0] - e0), 72'h8);
        check("t4_timeouts", 72'(to_cnt[0] - t0), 72'h1);
        check("t4_no_done", 72'(done_cnt[0] - d0), 72'h0);
        check("t4_first_byte", 72'(mon_q.size() > 0 ? mon_q[0] : 8'h00), 72'hA5);
        stuck[0] = 1'b0;

        // Reset pulse during byte 3 of 5, then a clean frame restarting with the sync byte.
        start_frame(0, 72'hDDCCBBAA);
        for (int c = 0; c < 200 && mon_q.size() < 3; c++) @(posedge clk);
        #1;
        check("t5_reached_byte3", 72'(mon_q.size()), 72'h3);
        d0 = done_cnt[0];
        reset_b = 1'b0;
        @(posedge clk); #1;
        reset_b = 1'b1;
        check("t5_tx_en", {71'h0, en[0]}, 72'h0);
        check("t5_busy", {71'h0, bsy[0]}, 72'h0);
        check("t5_byte", {64'h0, tb_byte[0]}, 72'h0);
        repeat (20) @(posedge clk); #1;
        check("t5_no_done", 72'(done_cnt[0] - d0), 72'h0);
        run_frame(0, 72'h87654321, "t5_after");

        // 3x3 words plus sync: ten bytes.
        r0 = en_rise[2];
        run_frame(2, 72'h998877665544332211, "t6");
        check("t6_bytes", 72'(en_rise[2] - r0), 72'd10);

        // Random frames with random TX busy lengths on every configuration.
        for (int i = 0; i < 3; i++) busy_len[i] = 0;
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 3; i++)
                run_frame(i, {8'($urandom), $urandom, $urandom}, $sformatf("rnd%0d_%0d", i, n));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
